// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Data-memory responder for the MEM stage. Stores are absorbed into a small
//   FIFO and committed to a slow backing array, one every WR_LAT cycles.
//   Loads are answered combinationally, forwarding from the youngest pending
//   store to the same word.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   MemRead        load request this cycle
//   MemWrite       store request this cycle
//   DataMemAddr    byte address; word index = DataMemAddr[IDX_W+1:2]
//   DataMemWrite   store data
//   DataMemRead    load data (combinational, 0 when not a valid load)
//   SBFull/SBEmpty store-buffer occupancy flags (registered state only)
//   Overflow       sticky: a store was dropped because the buffer was full
//   Misalign       sticky: an access had DataMemAddr[1:0] != 0
//
// Optional build macro DMEM_STATS_EN adds saturating 32-bit counters:
//   RdCount (aligned loads), WrCount (accepted stores),
//   FullCycles (cycles with SBFull=1).
module dmem_store_buffer #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned SB_DEPTH    = 4,
  parameter int unsigned WR_LAT      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DataMemAddr,
  input  logic [31:0] DataMemWrite,
  output logic [31:0] DataMemRead,
  output logic        SBFull,
  output logic        SBEmpty,
  output logic        Overflow,
  output logic        Misalign
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] RdCount,
  output logic [31:0] WrCount,
  output logic [31:0] FullCycles
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DC_W  = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SB_DEPTH);

  logic [31:0]      mem     [DEPTH_WORDS];
  logic [IDX_W-1:0] sb_idx  [SB_DEPTH];
  logic [31:0]      sb_data [SB_DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DC_W-1:0]  dcnt;

  logic             aligned;
  logic [IDX_W-1:0] idx;
  logic             pop;
  logic             push;
  logic             drop;
  logic [31:0]      rd_data;
  logic [PTR_W-1:0] slot;
  logic             unused_addr_hi;

  assign aligned        = (DataMemAddr[1:0] == 2'b00);
  assign idx            = DataMemAddr[IDX_W+1:2];
  assign unused_addr_hi = ^DataMemAddr[31:IDX_W+2];

  assign SBFull  = (count == CNT_MAX);
  assign SBEmpty = (count == '0);

  assign pop  = !SBEmpty && (dcnt == DC_LAST);
  assign push = MemWrite && aligned && (!SBFull || pop);
  assign drop = MemWrite && aligned && SBFull && !pop;

  // Walk entries oldest to youngest so the last match wins. The head being
  // committed this cycle is still counted, so the array write and the
  // forwarded value never disagree within a cycle.
  always_comb begin
    rd_data = mem[idx];
    slot    = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (sb_idx[slot] == idx)) rd_data = sb_data[slot];
    end
    DataMemRead = (MemRead && aligned) ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      dcnt     <= '0;
      Overflow <= 1'b0;
      Misalign <= 1'b0;
    end else begin
      if (pop) begin
        mem[sb_idx[head]] <= sb_data[head];
        head              <= head + PTR_W'(1);
      end
      if (push) begin
        sb_idx[tail]  <= idx;
        sb_data[tail] <= DataMemWrite;
        tail          <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (SBEmpty || pop) dcnt <= '0;
      else                dcnt <= dcnt + DC_W'(1);
      if (drop) Overflow <= 1'b1;
      if ((MemRead || MemWrite) && !aligned) Misalign <= 1'b1;
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      RdCount    <= '0;
      WrCount    <= '0;
      FullCycles <= '0;
    end else begin
      if (MemRead && aligned && (RdCount != '1)) RdCount <= RdCount + 32'd1;
      if (push && (WrCount != '1))               WrCount <= WrCount + 32'd1;
      if (SBFull && (FullCycles != '1))          FullCycles <= FullCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer
//   Directed bench for dmem_store_buffer with default parameters
//   (DEPTH_WORDS=1024, SB_DEPTH=4, WR_LAT=3). Inputs change 1ns after each
//   rising edge; outputs are checked 1ns after inputs settle.
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] DataMemAddr;
  logic [31:0] DataMemWrite;
  logic [31:0] DataMemRead;
  logic        SBFull;
  logic        SBEmpty;
  logic        Overflow;
  logic        Misalign;
`ifdef DMEM_STATS_EN
  logic [31:0] RdCount;
  logic [31:0] WrCount;
  logic [31:0] FullCycles;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(
    .DEPTH_WORDS(1024),
    .SB_DEPTH   (4),
    .WR_LAT     (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .DataMemAddr (DataMemAddr),
    .DataMemWrite(DataMemWrite),
    .DataMemRead (DataMemRead),
    .SBFull      (SBFull),
    .SBEmpty     (SBEmpty),
    .Overflow    (Overflow),
    .Misalign    (Misalign)
`ifdef DMEM_STATS_EN
    ,
    .RdCount     (RdCount),
    .WrCount     (WrCount),
    .FullCycles  (FullCycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    MemWrite     = 1'b1;
    DataMemAddr  = addr;
    DataMemWrite = data;
    tick();
    MemWrite     = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MemRead     = 1'b1;
    DataMemAddr = addr;
    #1;
    check_eq(tag, DataMemRead, exp);
    MemRead     = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int n = 0; n < 40 && !SBEmpty; n++) tick();
    check_eq(tag, {31'b0, SBEmpty}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    DataMemAddr = '0; DataMemWrite = '0;
    tick();
    tick();
    rst = 1'b0;

    // 1. Reset state
    read_check("rst_read40", 32'h40, 32'h0);
    check_eq("rst_empty", {31'b0, SBEmpty},  32'd1);
    check_eq("rst_full",  {31'b0, SBFull},   32'd0);
    check_eq("rst_ovf",   {31'b0, Overflow}, 32'd0);
    check_eq("rst_mis",   {31'b0, Misalign}, 32'd0);

    // 2. Store then forwarded load; commit exactly 3 edges after enqueue
    do_write(32'h10, 32'hDEADBEEF);                 // edge E
    read_check("fwd_10", 32'h10, 32'hDEADBEEF);
    check_eq("e0_empty", {31'b0, SBEmpty}, 32'd0);
    tick();                                         // E+1
    check_eq("e1_empty", {31'b0, SBEmpty}, 32'd0);
    tick();                                         // E+2
    check_eq("e2_empty", {31'b0, SBEmpty}, 32'd0);
    tick();                                         // E+3: commit
    check_eq("e3_empty", {31'b0, SBEmpty}, 32'd1);
    read_check("arr_10", 32'h10, 32'hDEADBEEF);
    read_check("wrap_1010", 32'h1010, 32'hDEADBEEF);

    // Simultaneous load+store: load sees the value before this store
    MemRead = 1'b1; MemWrite = 1'b1;
    DataMemAddr = 32'h10; DataMemWrite = 32'hCAFEF00D;
    #1;
    check_eq("rw_old", DataMemRead, 32'hDEADBEEF);
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    read_check("rw_new", 32'h10, 32'hCAFEF00D);
    wait_empty("drain_rw");
    read_check("rw_arr", 32'h10, 32'hCAFEF00D);

    // 3. Youngest match
    do_write(32'h8, 32'h11);                        // edge A
    do_write(32'h8, 32'h22);                        // A+1
    read_check("young_fwd", 32'h8, 32'h22);
    tick();                                         // A+2
    tick();                                         // A+3: 0x11 committed
    tick();                                         // A+4
    read_check("young_mid", 32'h8, 32'h22);
    wait_empty("drain_young");
    read_check("young_arr", 32'h8, 32'h22);

    // 4/5. Fill, overflow, push-on-pop. Starting empty, a pop happens at F+3,
    // so the buffer reaches 4 entries at F+4 and the store at F+5 is dropped.
    do_write(32'h00, 32'h100);                      // F   cnt 1
    do_write(32'h04, 32'h101);                      // F+1 cnt 2
    do_write(32'h08, 32'h102);                      // F+2 cnt 3
    do_write(32'h0C, 32'h103);                      // F+3 pop+push cnt 3
    check_eq("f3_full", {31'b0, SBFull}, 32'd0);
    do_write(32'h10, 32'h104);                      // F+4 cnt 4
    check_eq("f4_full", {31'b0, SBFull},   32'd1);
    check_eq("f4_ovf",  {31'b0, Overflow}, 32'd0);
    do_write(32'h14, 32'h105);                      // F+5 full, no pop: dropped
    check_eq("f5_full", {31'b0, SBFull},   32'd1);
    check_eq("f5_ovf",  {31'b0, Overflow}, 32'd1);
    do_write(32'h20, 32'h2020);                     // F+6 pop+push: stays full
    check_eq("f6_full", {31'b0, SBFull}, 32'd1);
    read_check("pop_push_fwd", 32'h20, 32'h2020);
    wait_empty("drain_fill");
    read_check("drop_14", 32'h14, 32'h0);
    read_check("arr_20",  32'h20, 32'h2020);
    read_check("arr_00",  32'h00, 32'h100);
    read_check("arr_0c",  32'h0C, 32'h103);
    read_check("arr_10b", 32'h10, 32'h104);

    // 6. Misalign, then reset mid-drain
    do_write(32'h3, 32'h77);
    check_eq("mis_set",   {31'b0, Misalign}, 32'd1);
    check_eq("mis_empty", {31'b0, SBEmpty},  32'd1);
    read_check("mis_read0", 32'h3, 32'h0);
    do_write(32'h30, 32'h55);
    check_eq("pend_empty", {31'b0, SBEmpty}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    read_check("rst2_30", 32'h30, 32'h0);
    read_check("rst2_00", 32'h00, 32'h0);
    check_eq("rst2_mis",   {31'b0, Misalign}, 32'd0);
    check_eq("rst2_ovf",   {31'b0, Overflow}, 32'd0);
    check_eq("rst2_empty", {31'b0, SBEmpty},  32'd1);
    tick();
    tick();
    tick();
    tick();
    read_check("rst2_30_late", 32'h30, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
